// File: rtl/fifo_pack4.sv
// Single-clock packing FIFO: DSIZE-bit writes every clock, 4*DSIZE-bit packed reads on a DIV-clock tick.
// Optional sticky overflow flag werr enabled by defining FIFO_PACK4_OVERFLOW_FLAG_EN.
module fifo_pack4 #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int DIV   = 4
) (
    input  logic                 wclk,
    input  logic                 wrstn,
    input  logic                 wren,
    input  logic [DSIZE-1:0]     wdata,
    input  logic                 rden,
    output logic                 wfull,
    output logic                 rempty,
    output logic [4*DSIZE-1:0]   rdata,
    output logic                 rdready,
    output logic                 rd_tick,
    output logic [ASIZE-1:0]     wraddr,
    output logic [ASIZE-1:0]     rdaddr,
    output logic                 werr
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [ASIZE:0]  FULL_C      = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0]  EMPTY_C     = (ASIZE+1)'(0);
    localparam logic [ASIZE:0]  PACK_C      = (ASIZE+1)'(4);
    localparam logic [ASIZE:0]  ONE_C       = (ASIZE+1)'(1);
    localparam logic [ASIZE:0]  NET_C       = (ASIZE+1)'(3);
    localparam logic [CW-1:0]   TICK_LAST_C = CW'(DIV - 1);

    logic [DSIZE-1:0]   mem_r [DEPTH];
    logic [ASIZE-1:0]   wraddr_r;
    logic [ASIZE-1:0]   rdaddr_r;
    logic [ASIZE:0]     count_r;
    logic [CW-1:0]      div_cnt_r;
    logic [4*DSIZE-1:0] rdata_r;
    logic               rdready_r;
    logic               rd_tick_r;
    logic               wfull_r;
    logic               rempty_r;

    logic               wr_acc_s;
    logic               rd_acc_s;
    logic [ASIZE:0]     count_nxt_s;
    logic [CW-1:0]      div_cnt_nxt_s;
    logic [4*DSIZE-1:0] rd_word_s;

    // Accept decisions, next occupancy and next divider value.
    always_comb begin
        wr_acc_s      = wren & ~wfull_r;
        rd_acc_s      = rd_tick_r & rden & (count_r >= PACK_C);
        count_nxt_s   = count_r;
        div_cnt_nxt_s = div_cnt_r;
        if (wr_acc_s && rd_acc_s) begin
            count_nxt_s = count_r - NET_C;
        end else if (wr_acc_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (rd_acc_s) begin
            count_nxt_s = count_r - PACK_C;
        end else begin
            count_nxt_s = count_r;
        end
        if (div_cnt_r == TICK_LAST_C) begin
            div_cnt_nxt_s = '0;
        end else begin
            div_cnt_nxt_s = div_cnt_r + CW'(1);
        end
    end

    // Gather four consecutive entries, oldest into the most significant lane; indices wrap mod depth.
    always_comb begin
        rd_word_s = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word_s[(3-i)*DSIZE +: DSIZE] = mem_r[rdaddr_r + ASIZE'(i)];
        end
    end

    // Storage array and write pointer; a full FIFO never accepts, even when a read frees space this cycle.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wraddr_r <= '0;
        end else if (wr_acc_s) begin
            mem_r[wraddr_r] <= wdata;
            wraddr_r        <= wraddr_r + ASIZE'(1);
        end
    end

    // Packed read path: rdata holds between accepted reads, rdready pulses for one clock.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            rdaddr_r  <= '0;
            rdata_r   <= '0;
            rdready_r <= 1'b0;
        end else if (rd_acc_s) begin
            rdaddr_r  <= rdaddr_r + ASIZE'(4);
            rdata_r   <= rd_word_s;
            rdready_r <= 1'b1;
        end else begin
            rdready_r <= 1'b0;
        end
    end

    // Occupancy, status flags and read-tick divider, all registered from next-state values.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            count_r   <= '0;
            wfull_r   <= 1'b0;
            rempty_r  <= 1'b1;
            div_cnt_r <= '0;
            rd_tick_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            wfull_r   <= (count_nxt_s == FULL_C);
            rempty_r  <= (count_nxt_s == EMPTY_C);
            div_cnt_r <= div_cnt_nxt_s;
            rd_tick_r <= (div_cnt_nxt_s == TICK_LAST_C);
        end
    end

`ifdef FIFO_PACK4_OVERFLOW_FLAG_EN
    logic werr_r;

    // Sticky overflow: any write attempt while full, cleared only by reset.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            werr_r <= 1'b0;
        end else if (wren && wfull_r) begin
            werr_r <= 1'b1;
        end
    end

    assign werr = werr_r;
`else
    assign werr = 1'b0;
`endif

    assign wfull   = wfull_r;
    assign rempty  = rempty_r;
    assign rdata   = rdata_r;
    assign rdready = rdready_r;
    assign rd_tick = rd_tick_r;
    assign wraddr  = wraddr_r;
    assign rdaddr  = rdaddr_r;

endmodule

// File: tb/tb_fifo_pack4.sv
// Directed bench for fifo_pack4: streaming, full/drain, partial data, pointer wrap and mid-stream reset.
module tb_fifo_pack4;

    logic        wclk;
    logic        wrstn;
    logic        wren;
    logic [7:0]  wdata;
    logic        rden;
    logic        wfull;
    logic        rempty;
    logic [31:0] rdata;
    logic        rdready;
    logic        rd_tick;
    logic [3:0]  wraddr;
    logic [3:0]  rdaddr;
    logic        werr;

    int n_cmp;
    int n_err;

    logic [31:0] exp_words [4];
    logic [31:0] werr_exp;

    fifo_pack4 #(.DSIZE(8), .ASIZE(4), .DIV(4)) dut (
        .wclk    (wclk),
        .wrstn   (wrstn),
        .wren    (wren),
        .wdata   (wdata),
        .rden    (rden),
        .wfull   (wfull),
        .rempty  (rempty),
        .rdata   (rdata),
        .rdready (rdready),
        .rd_tick (rd_tick),
        .wraddr  (wraddr),
        .rdaddr  (rdaddr),
        .werr    (werr)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wren  = 1'b0;
        rden  = 1'b0;
        wdata = 8'h00;
        @(negedge wclk);
        wrstn = 1'b0;
        @(negedge wclk);
        wrstn = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef FIFO_PACK4_OVERFLOW_FLAG_EN
        werr_exp = 32'd1;
`else
        werr_exp = 32'd0;
`endif
        wrstn = 1'b1;
        wren  = 1'b0;
        rden  = 1'b0;
        wdata = 8'h00;
        #2 wrstn = 1'b0;
        #2;
        check_eq("rst_wraddr",  32'(wraddr),  32'd0);
        check_eq("rst_rdaddr",  32'(rdaddr),  32'd0);
        check_eq("rst_rdata",   rdata,        32'h0);
        check_eq("rst_rdready", 32'(rdready), 32'd0);
        check_eq("rst_rd_tick", 32'(rd_tick), 32'd0);
        check_eq("rst_wfull",   32'(wfull),   32'd0);
        check_eq("rst_rempty",  32'(rempty),  32'd1);
        check_eq("rst_werr",    32'(werr),    32'd0);
        @(negedge wclk);
        wrstn = 1'b1;

        // Streaming: one byte per clock, reads enabled.
        exp_words[0] = 32'h01020304;
        exp_words[1] = 32'h05060708;
        exp_words[2] = 32'h090a0b0c;
        exp_words[3] = 32'h0d0e0f10;
        wren  = 1'b1;
        rden  = 1'b1;
        wdata = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            step();
            wdata = 8'(k + 1);
            if (k >= 16) wren = 1'b0;
            check_eq("stream_tick", 32'(rd_tick), 32'((k % 4) == 3));
            check_eq("stream_rdy",  32'(rdready), 32'((k >= 8) && ((k % 4) == 0)));
            if ((k >= 8) && ((k % 4) == 0)) check_eq("stream_data", rdata, exp_words[k/4 - 2]);
            if (k < 20) check_eq("stream_rempty", 32'(rempty), 32'd0);
        end
        rden = 1'b0;
        check_eq("stream_end_rempty", 32'(rempty), 32'd1);
        check_eq("stream_end_rdaddr", 32'(rdaddr), 32'd0);
        check_eq("stream_end_wraddr", 32'(wraddr), 32'd0);

        // Fill to full, then overflow attempts, then drain.
        do_reset();
        exp_words[0] = 32'h11121314;
        exp_words[1] = 32'h15161718;
        exp_words[2] = 32'h191a1b1c;
        exp_words[3] = 32'h1d1e1f20;
        wren  = 1'b1;
        wdata = 8'h11;
        for (int k = 1; k <= 18; k++) begin
            step();
            wdata = (k < 16) ? 8'(8'h11 + k) : 8'hEE;
            if (k == 15) check_eq("fill_wfull15", 32'(wfull), 32'd0);
            if (k == 16) begin
                check_eq("fill_wfull16",  32'(wfull),  32'd1);
                check_eq("fill_wraddr16", 32'(wraddr), 32'd0);
                check_eq("fill_werr16",   32'(werr),   32'd0);
            end
        end
        check_eq("ovf_wraddr", 32'(wraddr), 32'd0);
        check_eq("ovf_wfull",  32'(wfull),  32'd1);
        check_eq("ovf_werr",   32'(werr),   werr_exp);
        wren = 1'b0;
        rden = 1'b1;
        for (int k = 19; k <= 32; k++) begin
            step();
            check_eq("drain_rdy", 32'(rdready), 32'((k % 4) == 0));
            if ((k % 4) == 0) check_eq("drain_data", rdata, exp_words[k/4 - 5]);
            if (k == 19) check_eq("drain_wfull19", 32'(wfull), 32'd1);
            if (k == 20) check_eq("drain_wfull20", 32'(wfull), 32'd0);
            if (k == 31) check_eq("drain_rempty31", 32'(rempty), 32'd0);
        end
        check_eq("drain_rempty", 32'(rempty), 32'd1);
        check_eq("drain_rdaddr", 32'(rdaddr), 32'd0);

        // Fewer than four entries must not produce a read.
        do_reset();
        wren  = 1'b1;
        rden  = 1'b1;
        wdata = 8'hA1;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k < 3) wdata = 8'(8'hA1 + k);
            if (k == 3) wren = 1'b0;
            if (k == 9) begin
                wren  = 1'b1;
                wdata = 8'hA4;
            end
            if (k == 10) wren = 1'b0;
            check_eq("part_rdy", 32'(rdready), 32'(k == 12));
            if (k == 8)  check_eq("part_rdata_hold", rdata, 32'h0);
            if (k == 10) check_eq("part_rempty", 32'(rempty), 32'd0);
            if (k == 12) check_eq("part_data", rdata, 32'ha1a2a3a4);
        end

        // Pointer wrap: old entries 12..15 then new entries written at 0..3.
        do_reset();
        wren  = 1'b1;
        wdata = 8'h40;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k < 16) wdata = 8'(8'h40 + k);
            if (k == 16) begin
                wren = 1'b0;
                rden = 1'b1;
            end
            if (k == 28) begin
                rden  = 1'b0;
                wren  = 1'b1;
                wdata = 8'h50;
            end
            if ((k > 28) && (k < 32)) wdata = 8'(8'h50 + (k - 28));
            if (k == 32) begin
                wren = 1'b0;
                rden = 1'b1;
            end
            check_eq("wrap_rdy", 32'(rdready), 32'((k == 20) || (k == 24) || (k == 28) || (k == 36) || (k == 40)));
            if (k == 20) check_eq("wrap_d20", rdata, 32'h40414243);
            if (k == 28) check_eq("wrap_d28", rdata, 32'h48494a4b);
            if (k == 32) check_eq("wrap_wraddr32", 32'(wraddr), 32'd4);
            if (k == 36) begin
                check_eq("wrap_d36",      rdata,        32'h4c4d4e4f);
                check_eq("wrap_rdaddr36", 32'(rdaddr),  32'd0);
            end
            if (k == 40) begin
                check_eq("wrap_d40",      rdata,        32'h50515253);
                check_eq("wrap_rdaddr40", 32'(rdaddr),  32'd4);
                check_eq("wrap_rempty40", 32'(rempty),  32'd1);
            end
        end
        rden = 1'b0;

        // Reset asserted mid-stream.
        do_reset();
        wren  = 1'b1;
        rden  = 1'b1;
        wdata = 8'h61;
        for (int k = 1; k <= 10; k++) begin
            step();
            wdata = 8'(8'h61 + k);
        end
        check_eq("mid_pre_rdata", rdata, 32'h61626364);
        #2 wrstn = 1'b0;
        #1;
        check_eq("mid_wraddr",  32'(wraddr),  32'd0);
        check_eq("mid_rdaddr",  32'(rdaddr),  32'd0);
        check_eq("mid_rdata",   rdata,        32'h0);
        check_eq("mid_rdready", 32'(rdready), 32'd0);
        check_eq("mid_rd_tick", 32'(rd_tick), 32'd0);
        check_eq("mid_wfull",   32'(wfull),   32'd0);
        check_eq("mid_rempty",  32'(rempty),  32'd1);
        check_eq("mid_werr",    32'(werr),    32'd0);
        wren = 1'b0;
        rden = 1'b0;
        @(posedge wclk);
        @(negedge wclk);
        wrstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq("post_tick", 32'(rd_tick), 32'((k % 4) == 3));
        end
        check_eq("post_rempty", 32'(rempty), 32'd1);
        check_eq("post_rdata",  rdata,       32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
